// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, resolves branch/jump redirects and fills MEM/WB.
// Optional build macro DMEM_TIMEOUT_EN adds a 4-bit wait counter that abandons a silent access with mem_err.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  wb_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        jump_in,
    input  logic [31:0] branch_target,
    input  logic        zero_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    input  logic [31:0] jump_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        valid_out,
    output logic [1:0]  wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_out,
    output logic [4:0]  dest_out,
    output logic        mem_err
);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_wb;
    logic [4:0]  r_dest;

    logic        r_valid;
    logic [1:0]  r_wb_out;
    logic [31:0] r_rdata;
    logic [31:0] r_alu;
    logic [4:0]  r_dest_out;

    logic        w_access;
    logic        w_mem_op;
    logic        w_timeout;
    logic        w_stall;
    logic        w_redirect;

    assign w_access = (r_state == ST_ACCESS);
    assign w_mem_op = in_valid & (mem_read_in | mem_write_in);

`ifdef DMEM_TIMEOUT_EN
    logic [3:0]  r_wait_cnt;
    logic        r_mem_err;

    assign w_timeout = w_access & ~dmem_ack & (r_wait_cnt == 4'hF);

    // Counter starts at 0 in the first ACCESS cycle, so it reads 15 after 15 silent cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'h0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if (!w_access) begin
                r_wait_cnt <= 4'h0;
            end else if (!dmem_ack && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 4'h1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    // Redirect only fires from IDLE, so a stalled memory instruction cannot redirect twice.
    always_comb begin
        w_stall    = 1'b0;
        w_redirect = 1'b0;
        if (!rst) begin
            if (w_access) begin
                w_stall = ~dmem_ack & ~w_timeout;
            end else begin
                w_stall    = w_mem_op;
                w_redirect = in_valid & (jump_in | (branch_in & zero_in));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_we       <= 1'b0;
            r_wb       <= 2'b00;
            r_dest     <= 5'd0;
            r_valid    <= 1'b0;
            r_wb_out   <= 2'b00;
            r_rdata    <= 32'h0;
            r_alu      <= 32'h0;
            r_dest_out <= 5'd0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_addr  <= alu_result;
                        r_wdata <= store_data;
                        r_we    <= mem_write_in;
                        r_wb    <= wb_in;
                        r_dest  <= dest_reg;
                        r_valid <= 1'b0;
                    end else if (in_valid) begin
                        r_valid    <= 1'b1;
                        r_wb_out   <= wb_in;
                        r_rdata    <= 32'h0;
                        r_alu      <= alu_result;
                        r_dest_out <= dest_reg;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        r_valid    <= 1'b1;
                        r_wb_out   <= r_wb;
                        r_rdata    <= r_we ? 32'h0 : dmem_rdata;
                        r_alu      <= r_addr;
                        r_dest_out <= r_dest;
                    end else if (w_timeout) begin
                        // An abandoned access retires with writeback disabled.
                        r_valid    <= 1'b1;
                        r_wb_out   <= 2'b00;
                        r_rdata    <= 32'h0;
                        r_alu      <= r_addr;
                        r_dest_out <= r_dest;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dmem_req      = w_access;
    assign dmem_we       = w_access & r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign stall         = w_stall;
    assign redirect      = w_redirect;
    assign redirect_pc   = w_redirect ? (jump_in ? jump_target : branch_target) : 32'h0;
    assign valid_out     = r_valid;
    assign wb_out        = r_wb_out;
    assign read_data_out = r_rdata;
    assign alu_out       = r_alu;
    assign dest_out      = r_dest_out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random instructions against a transaction-level model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  wb_in;
    logic        branch_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        jump_in;
    logic [31:0] branch_target;
    logic        zero_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic [31:0] jump_target;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic [1:0]  wb_out;
    logic [31:0] read_data_out;
    logic [31:0] alu_out;
    logic [4:0]  dest_out;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic        br;
        logic        rd;
        logic        wr;
        logic        jmp;
        logic        zero;
        logic [31:0] bt;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] jt;
        logic [4:0]  dest;
    } instr_t;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .wb_in         (wb_in),
        .branch_in     (branch_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .jump_in       (jump_in),
        .branch_target (branch_target),
        .zero_in       (zero_in),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .dest_reg      (dest_reg),
        .jump_target   (jump_target),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .valid_out     (valid_out),
        .wb_out        (wb_out),
        .read_data_out (read_data_out),
        .alu_out       (alu_out),
        .dest_out      (dest_out),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic instr_t makeInstr(input logic valid, input logic [1:0] wb, input logic br,
                                         input logic zero, input logic jmp, input logic rd,
                                         input logic wr, input logic [31:0] alu, input logic [31:0] st,
                                         input logic [4:0] dest, input logic [31:0] bt,
                                         input logic [31:0] jt);
        instr_t r;
        r.valid = valid; r.wb = wb; r.br = br; r.zero = zero; r.jmp = jmp;
        r.rd = rd; r.wr = wr; r.alu = alu; r.st = st; r.dest = dest; r.bt = bt; r.jt = jt;
        return r;
    endfunction

    function automatic instr_t randInstr();
        instr_t r;
        r.valid = ($urandom_range(0, 7) != 0);
        r.wb    = 2'($urandom_range(0, 3));
        r.br    = ($urandom_range(0, 2) == 0);
        r.zero  = ($urandom_range(0, 1) == 0);
        r.jmp   = ($urandom_range(0, 4) == 0);
        r.rd    = ($urandom_range(0, 2) == 0);
        r.wr    = ($urandom_range(0, 2) == 0);
        r.bt    = $urandom;
        r.alu   = $urandom;
        r.st    = $urandom;
        r.jt    = $urandom;
        r.dest  = 5'($urandom_range(0, 31));
        return r;
    endfunction

    task automatic driveInstr(input instr_t ins);
        in_valid      = ins.valid;
        wb_in         = ins.wb;
        branch_in     = ins.br;
        zero_in       = ins.zero;
        jump_in       = ins.jmp;
        mem_read_in   = ins.rd;
        mem_write_in  = ins.wr;
        branch_target = ins.bt;
        alu_result    = ins.alu;
        store_data    = ins.st;
        dest_reg      = ins.dest;
        jump_target   = ins.jt;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires the instruction.
    task automatic applyStimulus(input instr_t ins, input int ackDelay, input logic [31:0] ackData);
        logic        expRedirect;
        logic [31:0] expPc;
        logic        isMem;
        driveInstr(ins);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        expRedirect = ins.valid && (ins.jmp || (ins.br && ins.zero));
        expPc       = !expRedirect ? 32'h0 : (ins.jmp ? ins.jt : ins.bt);
        isMem       = ins.valid && (ins.rd || ins.wr);
        @(negedge clk);
        checkOutput("redirect", 32'(redirect), 32'(expRedirect));
        checkOutput("redirect_pc", redirect_pc, expPc);
        checkOutput("stall_idle", 32'(stall), 32'(isMem));
        checkOutput("dmem_req_idle", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        if (!isMem) begin
            checkOutput("valid_out", 32'(valid_out), 32'(ins.valid));
            if (ins.valid) begin
                checkOutput("wb_out", 32'(wb_out), 32'(ins.wb));
                checkOutput("alu_out", alu_out, ins.alu);
                checkOutput("dest_out", 32'(dest_out), 32'(ins.dest));
                checkOutput("read_data_alu", read_data_out, 32'h0);
            end
        end else begin
            checkOutput("valid_entry", 32'(valid_out), 32'h0);
            for (int c = 0; c <= ackDelay; c++) begin
                dmem_ack   = (c == ackDelay);
                dmem_rdata = (c == ackDelay) ? ackData : $urandom;
                @(negedge clk);
                checkOutput("dmem_req", 32'(dmem_req), 32'h1);
                checkOutput("dmem_we", 32'(dmem_we), 32'(ins.wr));
                checkOutput("dmem_addr", dmem_addr, ins.alu);
                checkOutput("dmem_wdata", dmem_wdata, ins.st);
                checkOutput("stall_access", 32'(stall), 32'(c != ackDelay));
                checkOutput("redirect_access", 32'(redirect), 32'h0);
                @(posedge clk); #1;
                if (c != ackDelay) checkOutput("valid_wait", 32'(valid_out), 32'h0);
            end
            dmem_ack = 1'b0;
            checkOutput("valid_mem", 32'(valid_out), 32'h1);
            checkOutput("wb_mem", 32'(wb_out), 32'(ins.wb));
            checkOutput("alu_mem", alu_out, ins.alu);
            checkOutput("dest_mem", 32'(dest_out), 32'(ins.dest));
            checkOutput("read_data_mem", read_data_out, ins.wr ? 32'h0 : ackData);
            checkOutput("dmem_req_done", 32'(dmem_req), 32'h0);
        end
        checkOutput("mem_err", 32'(mem_err), 32'h0);
    endtask

    initial begin
        instr_t ins;
        rst = 1'b1;
        driveInstr(makeInstr(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0));
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid_out), 32'h0);
        checkOutput("rst_wb", 32'(wb_out), 32'h0);
        checkOutput("rst_rdata", read_data_out, 32'h0);
        checkOutput("rst_alu", alu_out, 32'h0);
        checkOutput("rst_dest", 32'(dest_out), 32'h0);
        checkOutput("rst_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'h0);
        driveInstr(makeInstr(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd1, 32'h100, 32'h200));
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_redirect", 32'(redirect), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        driveInstr(makeInstr(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0));
        @(posedge clk); #1;

        applyStimulus(makeInstr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 32'h0, 32'h0), 0, 32'h0);
        applyStimulus(makeInstr(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 32'h0, 32'h0), 3, 32'hDEAD_BEEF);
        applyStimulus(makeInstr(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h100, 32'h0), 0, 32'h0);
        applyStimulus(makeInstr(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h100, 32'h0), 0, 32'h0);
        applyStimulus(makeInstr(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h100, 32'h200), 0, 32'h0);
        applyStimulus(makeInstr(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h1234, 5'd9, 32'h0, 32'h0), 2, 32'hFFFF_FFFF);
        applyStimulus(makeInstr(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h0, 5'd3, 32'h300, 32'h0), 1, 32'hCAFE_F00D);

        for (int n = 0; n < 60; n++) begin
            ins = randInstr();
            applyStimulus(ins, $urandom_range(0, 6), $urandom);
        end

        // Reset arriving in the second ACCESS cycle, followed by a stray ack.
        driveInstr(makeInstr(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h55, 5'd4, 32'h0, 32'h0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_access_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_access_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_access_valid", 32'(valid_out), 32'h0);
        checkOutput("rst_access_addr", dmem_addr, 32'h0);
        checkOutput("rst_access_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_access_alu", alu_out, 32'h0);
        checkOutput("rst_access_wb", 32'(wb_out), 32'h0);
        checkOutput("rst_access_dest", 32'(dest_out), 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checkOutput("stray_ack_valid", 32'(valid_out), 32'h0);
        checkOutput("stray_ack_req", 32'(dmem_req), 32'h0);
        checkOutput("stray_ack_rdata", read_data_out, 32'h0);

        // Memory that never answers.
        driveInstr(makeInstr(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h88, 32'h0, 5'd6, 32'h0, 32'h0));
        @(posedge clk); #1;
`ifdef DMEM_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checkOutput("timeout_stall", 32'(stall), 32'(c < 15));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("timeout_valid", 32'(valid_out), 32'h1);
        checkOutput("timeout_wb", 32'(wb_out), 32'h0);
        checkOutput("timeout_err", 32'(mem_err), 32'h1);
        checkOutput("timeout_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        checkOutput("timeout_err_pulse", 32'(mem_err), 32'h0);
`else
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checkOutput("hang_stall", 32'(stall), 32'h1);
            checkOutput("hang_err", 32'(mem_err), 32'h0);
            @(posedge clk); #1;
        end
        checkOutput("hang_valid", 32'(valid_out), 32'h0);
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        checkOutput("hang_release_valid", 32'(valid_out), 32'h1);
`endif
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous and active-high.
REQ-002 SHALL have in_valid in 1 (EX/MEM entry valid), wb_in in 2, branch_in in 1, mem_read_in in 1, mem_write_in in 1, jump_in in 1.
REQ-003 SHALL have branch_target in 32, zero_in in 1, alu_result in 32 (memory address and ALU value), store_data in 32, dest_reg in 5, jump_target in 32.
REQ-004 SHALL have memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_rdata in 32, dmem_ack in 1.
REQ-005 SHALL have control outputs: stall out 1 (EX/MEM hold), redirect out 1 (PC override and IF/ID/EX flush), redirect_pc out 32.
REQ-006 SHALL have MEM/WB outputs: valid_out 1, wb_out 2, read_data_out 32, alu_out 32, dest_out 5, mem_err 1.

Function
REQ-007 SHALL be a two-state FSM: IDLE, ACCESS.
REQ-008 In IDLE with in_valid=1 and no memory op: MEM/WB registers SHALL load wb_in, alu_result and dest_reg at the next edge, with valid_out=1 and read_data_out=0; latency is 1 cycle.
REQ-009 In IDLE with in_valid=0: valid_out SHALL be 0 after the next edge.
REQ-010 In IDLE with in_valid=1 and mem_read_in or mem_write_in set: stall SHALL be 1 combinationally; the FSM SHALL latch alu_result, store_data, wb_in, dest_reg and the op, and enter ACCESS at the next edge; valid_out SHALL be 0 after that edge.
REQ-011 In ACCESS: dmem_req=1; dmem_addr, dmem_wdata and dmem_we SHALL hold the latched values; stall = NOT dmem_ack.
REQ-012 On an ACCESS edge with dmem_ack=1: the FSM SHALL return to IDLE and load MEM/WB with valid_out=1. read_data_out SHALL be dmem_rdata for a read and 0 for a write.
REQ-013 If mem_read_in and mem_write_in are both set, the access SHALL be treated as a write (dmem_we=1).
REQ-014 dmem_ack SHALL be ignored in IDLE.
REQ-015 redirect is combinational. It SHALL be 1 only when state=IDLE and in_valid=1 and (jump_in OR (branch_in AND zero_in)).
REQ-016 redirect_pc SHALL be jump_target when jump_in=1, otherwise branch_target (jump has priority). It SHALL be 0 when redirect=0.
REQ-017 redirect SHALL assert at most once per instruction, including when a memory op stalls that instruction.
REQ-018 In IDLE with no memory op, and in ACCESS when dmem_ack=1, stall SHALL be 0.

Reset
REQ-019 rst=1 at an edge SHALL force state IDLE and clear all registered outputs to 0 (valid_out, wb_out, read_data_out, alu_out, dest_out, mem_err, latched address/data).
REQ-020 Reset during ACCESS SHALL drop dmem_req the cycle after the reset edge. Any later dmem_ack SHALL be ignored.
REQ-021 While rst=1, stall and redirect SHALL be 0.

Configuration
REQ-022 With macro DMEM_TIMEOUT_EN defined, a 4-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-023 When the counter reaches 15 with dmem_ack=0, in that cycle stall SHALL be 0. At the next edge the FSM SHALL return to IDLE, load MEM/WB with valid_out=1 and wb_out=00, and pulse mem_err=1 for one cycle.
REQ-024 With DMEM_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, mem_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-025 ALU op: in_valid=1, wb_in=10, alu_result=0x0000_0010, dest_reg=5, no mem op -> next cycle valid_out=1, wb_out=10, alu_out=0x10, dest_out=5, stall=0 throughout.
REQ-026 Load, ack after 3 ACCESS cycles, dmem_rdata=0xDEAD_BEEF, addr 0x40 -> stall=1 for 3 cycles then 0 in the ack cycle, dmem_addr=0x40; then read_data_out=0xDEAD_BEEF, valid_out=1.
REQ-027 Branch: branch_in=1, zero_in=1, branch_target=0x100 -> redirect=1, redirect_pc=0x100 for one cycle. Same with zero_in=0 -> redirect=0. With jump_in=1 and jump_target=0x200 also set -> redirect_pc=0x200.
REQ-028 Store with mem_read_in=1 and mem_write_in=1, store_data=0x1234 -> dmem_we=1, dmem_wdata=0x1234, read_data_out=0 after ack.
REQ-029 rst=1 asserted in the 2nd ACCESS cycle -> dmem_req=0 the next cycle, all outputs 0. A dmem_ack one cycle later -> no valid_out.
REQ-030 DMEM_TIMEOUT_EN defined, no ack -> after 15 ACCESS cycles: mem_err pulse, valid_out=1, wb_out=00, stall released. Undefined -> stall remains 1 indefinitely.
